dbg_reg_reader: RTL and testbench

//  Debug-side register read responder for the NPC core. A host/debug initiator issues
//  one-at-a-time read requests by index; the block fetches the GPR, CSR or PC value and

---
 rtl/dbg_reg_reader.sv | 105 ++++++++++
 tb/tb_dbg_reg_reader.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/dbg_reg_reader.sv
// Debug register read responder: GPR reads take 3 cycles to response (regfile port), CSR/PC/x0/illegal take 1.
// One request outstanding; the response is held stable and new requests are refused until it is accepted.
module dbg_reg_reader #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             dbg_req_valid,
  output logic             dbg_req_ready,
  input  logic [5:0]       dbg_req_addr,
  output logic             dbg_rsp_valid,
  input  logic             dbg_rsp_ready,
  output logic [XLEN-1:0]  dbg_rsp_data,
  output logic             dbg_rsp_err,
  output logic             gpr_ren,
  output logic [4:0]       gpr_raddr,
  input  logic [XLEN-1:0]  gpr_rdata,
  input  logic [XLEN-1:0]  csr_reg_0,
  input  logic [XLEN-1:0]  csr_reg_1,
  input  logic [XLEN-1:0]  csr_reg_2,
  input  logic [XLEN-1:0]  csr_reg_3,
  input  logic [XLEN-1:0]  pc,
  output logic [CNT_W-1:0] rsp_count
);

  typedef enum logic [1:0] {IDLE, RD, CAP, RSP} state_t;

  state_t          state, state_nxt;
  logic [4:0]      addr_q;
  logic [XLEN-1:0] data_q;
  logic            err_q;
  logic [CNT_W-1:0] cnt_q;
  logic            req_acc, rsp_acc, is_gpr;
  logic [XLEN-1:0] imm_data;
  logic            imm_err;

  assign req_acc = dbg_req_valid & dbg_req_ready;
  assign rsp_acc = dbg_rsp_valid & dbg_rsp_ready;
  assign is_gpr  = (dbg_req_addr[5] == 1'b0) && (dbg_req_addr[4:0] != 5'd0);

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (req_acc) state_nxt = is_gpr ? RD : RSP;
      RD:   state_nxt = CAP;
      CAP:  state_nxt = RSP;
      RSP:  if (dbg_rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    dbg_req_ready = (state == IDLE) && !reset;
    dbg_rsp_valid = (state == RSP);
    gpr_ren       = (state == RD);
    gpr_raddr     = (state == RD) ? addr_q : 5'd0;
  end

  // Non-GPR sources resolve immediately from the live values at the accept edge.
  always_comb begin
    imm_data = '0;
    imm_err  = 1'b0;
    case (dbg_req_addr)
      6'd32:   imm_data = csr_reg_0;
      6'd33:   imm_data = csr_reg_1;
      6'd34:   imm_data = csr_reg_2;
      6'd35:   imm_data = csr_reg_3;
      6'd36:   imm_data = pc;
      default: imm_err  = (dbg_req_addr > 6'd36);
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      addr_q <= 5'd0;
      data_q <= '0;
      err_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      if (req_acc) begin
        addr_q <= dbg_req_addr[4:0];
        if (!is_gpr) begin
          data_q <= imm_data;
          err_q  <= imm_err;
        end
      end
      if (state == CAP) begin
        data_q <= gpr_rdata;
        err_q  <= 1'b0;
      end
      if (rsp_acc) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign dbg_rsp_data = data_q;
  assign dbg_rsp_err  = err_q;
  assign rsp_count    = cnt_q;

endmodule

// File: tb/tb_dbg_reg_reader.sv
// Bench for dbg_reg_reader: transaction-level reference model checked every cycle, plus directed literal checks.
module tb_dbg_reg_reader;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        dbg_req_valid = 1'b0;
  logic        dbg_req_ready;
  logic [5:0]  dbg_req_addr = 6'd0;
  logic        dbg_rsp_valid;
  logic        dbg_rsp_ready = 1'b0;
  logic [63:0] dbg_rsp_data;
  logic        dbg_rsp_err;
  logic        gpr_ren;
  logic [4:0]  gpr_raddr;
  logic [63:0] gpr_rdata = 64'd0;
  logic [63:0] csr_reg_0 = 64'h0, csr_reg_1 = 64'h0, csr_reg_2 = 64'h0, csr_reg_3 = 64'h0;
  logic [63:0] pc = 64'h0;
  logic [3:0]  rsp_count;

  int errors = 0;
  int checks = 0;
  logic [63:0] regs [32];

  dbg_reg_reader #(.XLEN(64), .CNT_W(4)) dut (
    .clock(clock), .reset(reset),
    .dbg_req_valid(dbg_req_valid), .dbg_req_ready(dbg_req_ready), .dbg_req_addr(dbg_req_addr),
    .dbg_rsp_valid(dbg_rsp_valid), .dbg_rsp_ready(dbg_rsp_ready),
    .dbg_rsp_data(dbg_rsp_data), .dbg_rsp_err(dbg_rsp_err),
    .gpr_ren(gpr_ren), .gpr_raddr(gpr_raddr), .gpr_rdata(gpr_rdata),
    .csr_reg_0(csr_reg_0), .csr_reg_1(csr_reg_1), .csr_reg_2(csr_reg_2), .csr_reg_3(csr_reg_3),
    .pc(pc), .rsp_count(rsp_count)
  );

  always #5 clock = ~clock;

  // Synchronous regfile read port.
  always @(posedge clock) if (gpr_ren) gpr_rdata <= regs[gpr_raddr];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one pending transaction, latency by address class.
  bit          live = 0, busy = 0, is_g = 0;
  int          age = 0, lat = 0, cnt = 0;
  logic [4:0]  gaddr = 5'd0;
  logic [63:0] pend_d = 64'd0, last_d = 64'd0;
  logic        pend_e = 1'b0, last_e = 1'b0;

  always @(posedge clock) begin
    if (reset) begin
      live = 1; busy = 0; cnt = 0; last_d = 64'd0; last_e = 1'b0;
    end else if (live) begin
      if (busy) begin
        if (age >= lat && dbg_rsp_ready) begin
          busy = 0; cnt = (cnt + 1) % 16; last_d = pend_d; last_e = pend_e;
        end else age++;
      end else if (dbg_req_valid) begin
        busy = 1; age = 1; is_g = 0; gaddr = dbg_req_addr[4:0];
        pend_d = 64'd0; pend_e = 1'b0; lat = 1;
        if (dbg_req_addr >= 1 && dbg_req_addr <= 31) begin
          is_g = 1; lat = 3; pend_d = regs[dbg_req_addr[4:0]];
        end else if (dbg_req_addr == 32) pend_d = csr_reg_0;
        else if (dbg_req_addr == 33) pend_d = csr_reg_1;
        else if (dbg_req_addr == 34) pend_d = csr_reg_2;
        else if (dbg_req_addr == 35) pend_d = csr_reg_3;
        else if (dbg_req_addr == 36) pend_d = pc;
        else if (dbg_req_addr > 36) pend_e = 1'b1;
      end
    end
  end

  always @(negedge clock) begin
    if (live) begin
      logic ev, er;
      ev = busy && age >= lat;
      er = busy && is_g && age == 1;
      chk("req_ready", dbg_req_ready, !busy && !reset);
      chk("rsp_valid", dbg_rsp_valid, ev);
      chk("gpr_ren", gpr_ren, er);
      chk("gpr_raddr", gpr_raddr, er ? gaddr : 5'd0);
      chk("rsp_count", rsp_count, cnt[3:0]);
      if (ev) begin
        chk("rsp_data", dbg_rsp_data, pend_d);
        chk("rsp_err", dbg_rsp_err, pend_e);
      end else if (!busy) begin
        chk("idle_data", dbg_rsp_data, last_d);
        chk("idle_err", dbg_rsp_err, last_e);
      end
    end
  end

  task automatic tick;
    @(posedge clock); #1;
  endtask

  task automatic send(input logic [5:0] a);
    int n = 0;
    while (!dbg_req_ready && n < 50) begin tick; n++; end
    if (n >= 50) begin
      checks++; errors++;
      $display("FAIL req_ready_timeout: got 0 expected 1 at %0t", $time);
    end
    dbg_req_valid = 1'b1; dbg_req_addr = a;
    tick;
    dbg_req_valid = 1'b0; dbg_req_addr = 6'($urandom);
  endtask

  task automatic wait_valid(output int l);
    l = 1;
    while (!dbg_rsp_valid && l < 50) begin tick; l++; end
    if (!dbg_rsp_valid) begin
      checks++; errors++;
      $display("FAIL rsp_valid_timeout: got 0 expected 1 at %0t", $time);
    end
  endtask

  initial begin
    int l;
    for (int i = 0; i < 32; i++) regs[i] = {$urandom, $urandom};
    regs[5] = 64'h0000_0000_DEAD_BEEF;
    regs[3] = 64'h0123_4567_89AB_CDEF;
    tick; tick;
    chk("rst_req_ready", dbg_req_ready, 1'b0);
    chk("rst_rsp_valid", dbg_rsp_valid, 1'b0);
    chk("rst_data", dbg_rsp_data, 64'd0);
    chk("rst_gpr_ren", gpr_ren, 1'b0);
    chk("rst_count", rsp_count, 4'd0);
    reset = 1'b0; #1;
    chk("post_rst_ready", dbg_req_ready, 1'b1);

    // GPR read: 3-cycle latency.
    send(6'd5);
    chk("gpr5_ren_t1", gpr_ren, 1'b1);
    chk("gpr5_raddr_t1", gpr_raddr, 5'd5);
    wait_valid(l);
    chk("gpr5_latency", l, 3);
    chk("gpr5_data", dbg_rsp_data, 64'h0000_0000_DEAD_BEEF);
    chk("gpr5_err", dbg_rsp_err, 1'b0);
    dbg_rsp_ready = 1'b1; tick; dbg_rsp_ready = 1'b0;
    chk("gpr5_count", rsp_count, 4'd1);

    // PC sampled at accept, later change ignored.
    pc = 64'h8000_0000;
    send(6'd36);
    pc = 64'h8000_0004;
    chk("pc_valid_t1", dbg_rsp_valid, 1'b1);
    tick;
    chk("pc_data", dbg_rsp_data, 64'h8000_0000);
    dbg_rsp_ready = 1'b1; tick; dbg_rsp_ready = 1'b0;
    csr_reg_1 = 64'h1111_2222_3333_4444;
    send(6'd33);
    csr_reg_1 = 64'h5555;
    chk("csr1_data", dbg_rsp_data, 64'h1111_2222_3333_4444);
    dbg_rsp_ready = 1'b1; tick; dbg_rsp_ready = 1'b0;

    // Illegal index under 10 cycles of backpressure.
    send(6'd40);
    for (int i = 0; i < 10; i++) begin
      chk("bp_valid", dbg_rsp_valid, 1'b1);
      chk("bp_err", dbg_rsp_err, 1'b1);
      chk("bp_data", dbg_rsp_data, 64'd0);
      chk("bp_req_ready", dbg_req_ready, 1'b0);
      tick;
    end
    dbg_rsp_ready = 1'b1; tick;
    chk("bp_done_valid", dbg_rsp_valid, 1'b0);
    chk("bp_next_ready", dbg_req_ready, 1'b1);
    send(6'd0);
    chk("x0_valid", dbg_rsp_valid, 1'b1);
    chk("x0_data", dbg_rsp_data, 64'd0);
    chk("x0_err", dbg_rsp_err, 1'b0);
    tick;
    dbg_rsp_ready = 1'b0;

    // Reset while in CAP drops the request.
    send(6'd7);
    tick;
    reset = 1'b1; tick;
    chk("mid_rst_valid", dbg_rsp_valid, 1'b0);
    chk("mid_rst_ren", gpr_ren, 1'b0);
    chk("mid_rst_data", dbg_rsp_data, 64'd0);
    chk("mid_rst_count", rsp_count, 4'd0);
    reset = 1'b0;
    send(6'd3);
    wait_valid(l);
    chk("after_rst_data", dbg_rsp_data, 64'h0123_4567_89AB_CDEF);
    dbg_rsp_ready = 1'b1; tick;

    // 17 back-to-back reads from reset: 4-bit counter wraps to 1.
    reset = 1'b1; tick; reset = 1'b0;
    for (int i = 0; i < 17; i++) begin
      send(6'($urandom));
      wait_valid(l);
      tick;
    end
    chk("wrap_count", rsp_count, 4'd1);

    // Randomized traffic, checked by the model every cycle.
    for (int i = 0; i < 600; i++) begin
      int b;
      reset = ($urandom_range(0, 79) == 0);
      dbg_req_valid = $urandom_range(0, 1);
      b = $urandom_range(0, 3);
      dbg_req_addr = (b == 0) ? 6'($urandom_range(32, 36)) :
                     (b == 1) ? 6'($urandom_range(37, 63)) : 6'($urandom_range(0, 31));
      dbg_rsp_ready = ($urandom_range(0, 2) != 0);
      csr_reg_0 = {$urandom, $urandom}; csr_reg_1 = {$urandom, $urandom};
      csr_reg_2 = {$urandom, $urandom}; csr_reg_3 = {$urandom, $urandom};
      pc = {$urandom, $urandom};
      tick;
    end
    reset = 1'b0; dbg_req_valid = 1'b0;
    tick; tick;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
